// File: rtl/fb_arbiter.sv
// fb_arbiter: shares the single frame-buffer port between VGA scan-out reads,
// a full-screen clear engine and a small FIFO of producer pixel writes.
// Priority is scan-out, then clear, then FIFO.
module fb_arbiter #(
  parameter int H_W        = 10,
  parameter int V_W        = 9,
  parameter int DW         = 24,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               vga_valid,
  input  logic [H_W-1:0]     vga_h_addr,
  input  logic [V_W-1:0]     vga_v_addr,
  output logic [DW-1:0]      vga_data,
  input  logic               wr_req,
  input  logic [H_W-1:0]     wr_h,
  input  logic [V_W-1:0]     wr_v,
  input  logic [DW-1:0]      wr_data,
  output logic               wr_ready,
  input  logic               clr_start,
  input  logic [DW-1:0]      clr_color,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               err_oor,
  output logic [H_W+V_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [H_W-1:0] H_LIM   = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_LIM   = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] H_LAST  = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_ACTIVE - 1);
  localparam logic [PW:0]    DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state;
  logic [H_W-1:0]   clr_h;
  logic [V_W-1:0]   clr_v;
  logic [DW-1:0]    clr_col_q;

  logic [H_W-1:0]   fifo_h [FIFO_DEPTH];
  logic [V_W-1:0]   fifo_v [FIFO_DEPTH];
  logic [DW-1:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic             push;
  logic             pop;
  logic             head_oor;

  // Full flag depends only on the registered count, never on a same-cycle pop.
  assign wr_ready = (count < DEPTH_C);
  assign push     = wr_req && wr_ready;
  assign head_oor = (fifo_h[rd_ptr] >= H_LIM) || (fifo_v[rd_ptr] >= V_LIM);

  // Port mux: scan-out wins, then the clear walk, then the FIFO head.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    vga_data  = '0;
    pop       = 1'b0;
    if (vga_valid) begin
      mem_addr = {vga_h_addr, vga_v_addr};
      vga_data = mem_rdata;
    end else if (state == CLEAR) begin
      mem_addr  = {clr_h, clr_v};
      mem_we    = 1'b1;
      mem_wdata = clr_col_q;
    end else if (count != '0) begin
      mem_addr  = {fifo_h[rd_ptr], fifo_v[rd_ptr]};
      mem_wdata = fifo_d[rd_ptr];
      mem_we    = !head_oor;
      pop       = 1'b1;
    end
  end

  // Clear sequencer: walks every visible pixel, stepping only when it owns the port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      clr_h    <= '0;
      clr_v    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_h    <= '0;
            clr_v    <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (!vga_valid) begin
            if (clr_h == H_LAST) begin
              clr_h <= '0;
              if (clr_v == V_LAST) begin
                clr_v    <= '0;
                state    <= IDLE;
                clr_busy <= 1'b0;
                clr_done <= 1'b1;
              end else begin
                clr_v <= clr_v + 1'b1;
              end
            end else begin
              clr_h <= clr_h + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear colour is captured once at start and held for the whole walk.
  always_ff @(posedge clock) begin
    if (state == IDLE && clr_start) clr_col_q <= clr_color;
  end

  // FIFO bookkeeping and the sticky out-of-range flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_oor <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop && head_oor) err_oor <= 1'b1;
    end
  end

  // FIFO storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_h[wr_ptr] <= wr_h;
      fifo_v[wr_ptr] <= wr_v;
      fifo_d[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed bench for fb_arbiter using a reduced 16x8 screen.
module tb_fb_arbiter;

  localparam int H_W = 10;
  localparam int V_W = 9;
  localparam int DW  = 24;
  localparam int HA  = 16;
  localparam int VA  = 8;
  localparam int N   = HA * VA;
  localparam int EW  = H_W + V_W + DW;

  logic               clock;
  logic               resetn;
  logic               vga_valid;
  logic [H_W-1:0]     vga_h_addr;
  logic [V_W-1:0]     vga_v_addr;
  logic [DW-1:0]      vga_data;
  logic               wr_req;
  logic [H_W-1:0]     wr_h;
  logic [V_W-1:0]     wr_v;
  logic [DW-1:0]      wr_data;
  logic               wr_ready;
  logic               clr_start;
  logic [DW-1:0]      clr_color;
  logic               clr_busy;
  logic               clr_done;
  logic               err_oor;
  logic [H_W+V_W-1:0] mem_addr;
  logic               mem_we;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [EW-1:0] log_q[$];

  fb_arbiter #(
    .H_W(H_W), .V_W(V_W), .DW(DW), .H_ACTIVE(HA), .V_ACTIVE(VA), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .resetn(resetn),
    .vga_valid(vga_valid), .vga_h_addr(vga_h_addr), .vga_v_addr(vga_v_addr),
    .vga_data(vga_data),
    .wr_req(wr_req), .wr_h(wr_h), .wr_v(wr_v), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .clr_done(clr_done), .err_oor(err_oor),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mid-cycle write logger and clr_done pulse counter.
  always @(negedge clock) begin
    if (resetn && mem_we) log_q.push_back({mem_addr, mem_wdata});
    if (resetn && clr_done) done_cnt = done_cnt + 1;
  end

  function automatic logic [EW-1:0] ent(input int h, input int v, input logic [DW-1:0] d);
    return {H_W'(h), V_W'(v), d};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", clr_done); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL rst_oor: got %b want 0", err_oor); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_read();
    vga_valid = 1'b1; vga_h_addr = 10'd5; vga_v_addr = 9'd7; mem_rdata = 24'hABCDEF;
    #1;
    checks++; if (vga_data !== 24'hABCDEF) begin errors++; $display("FAIL rd_data: got %h want abcdef", vga_data); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== {10'd5, 9'd7}) begin errors++; $display("FAIL rd_addr: got %h want %h", mem_addr, {10'd5, 9'd7}); end
    vga_valid = 1'b0;
    #1;
    checks++; if (vga_data !== 24'h0) begin errors++; $display("FAIL rd_idle: got %h want 0", vga_data); end
    step();
  endtask

  task automatic test_fifo_order();
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_h = H_W'(10 + i); wr_v = V_W'(2 + i); wr_data = 24'h100000 + 24'(i);
      #1;
      checks++; if (mem_we !== (i != 0)) begin errors++; $display("FAIL ord_we%0d: got %b want %b", i, mem_we, (i != 0)); end
      step();
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ord_ready%0d: got %b want 1", i, wr_ready); end
    end
    wr_req = 1'b0;
    repeat (3) step();
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL ord_cnt: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== ent(10 + i, 2 + i, 24'h100000 + 24'(i))) begin
        errors++; $display("FAIL ord_ent%0d: got %h want %h", i, log_q[i], ent(10 + i, 2 + i, 24'h100000 + 24'(i)));
      end
    end
  endtask

  task automatic test_hold();
    log_q.delete();
    vga_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_h = H_W'(i); wr_v = V_W'(i + 1); wr_data = 24'h200000 + 24'(i);
      step();
    end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_full: got %b want 0", wr_ready); end
    wr_h = 10'd9; wr_v = 9'd6; wr_data = 24'h2FFFFF;
    step();
    wr_req = 1'b0;
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL hold_nowr: got %0d want 0", log_q.size()); end
    vga_valid = 1'b0;
    repeat (6) step();
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL hold_cnt: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== ent(i, i + 1, 24'h200000 + 24'(i))) begin
        errors++; $display("FAIL hold_ent%0d: got %h want %h", i, log_q[i], ent(i, i + 1, 24'h200000 + 24'(i)));
      end
    end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_clear_full();
    int d0;
    int bad;
    log_q.delete();
    d0 = done_cnt;
    clr_color = 24'h00FF00; clr_start = 1'b1;
    wr_req = 1'b1; wr_h = 10'd2; wr_v = 9'd2; wr_data = 24'h123456;
    step();
    clr_start = 1'b0; wr_req = 1'b0;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_on: got %b want 1", clr_busy); end
    for (int k = 0; k < 400 && !clr_done; k++) step();
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL clr_timeout: got %b want 1", clr_done); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_off: got %b want 0", clr_busy); end
    checks++; if (log_q.size() != N) begin errors++; $display("FAIL clr_cnt: got %0d want %0d", log_q.size(), N); end
    bad = 0;
    for (int i = 0; i < N && i < log_q.size(); i++)
      if (log_q[i] !== ent(i % HA, i / HA, 24'h00FF00)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_seq: got %0d bad want 0", bad); end
    if (log_q.size() >= N) begin
      checks++;
      if (log_q[N-1] !== ent(HA - 1, VA - 1, 24'h00FF00)) begin
        errors++; $display("FAIL clr_last: got %h want %h", log_q[N-1], ent(HA - 1, VA - 1, 24'h00FF00));
      end
    end
    step();
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL clr_pulse: got %b want 0", clr_done); end
    repeat (2) step();
    checks++; if (log_q.size() != N + 1) begin errors++; $display("FAIL clr_fifo_cnt: got %0d want %0d", log_q.size(), N + 1); end
    if (log_q.size() > 0) begin
      checks++;
      if (log_q[log_q.size()-1] !== ent(2, 2, 24'h123456)) begin
        errors++; $display("FAIL clr_fifo_after: got %h want %h", log_q[log_q.size()-1], ent(2, 2, 24'h123456));
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL clr_done_cnt: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_clear_toggle();
    int bad;
    log_q.delete();
    clr_color = 24'h0000FF; clr_start = 1'b1; vga_valid = 1'b0;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 800 && !clr_done; k++) begin
      vga_valid = ~vga_valid;
      if (k == 41) begin clr_start = 1'b1; clr_color = 24'hFF0000; end
      if (k == 42) clr_start = 1'b0;
      step();
    end
    vga_valid = 1'b0; clr_start = 1'b0;
    checks++; if (clr_done !== 1'b1) begin errors++; $display("FAIL tog_timeout: got %b want 1", clr_done); end
    checks++; if (log_q.size() != N) begin errors++; $display("FAIL tog_cnt: got %0d want %0d", log_q.size(), N); end
    bad = 0;
    for (int i = 0; i < N && i < log_q.size(); i++)
      if (log_q[i] !== ent(i % HA, i / HA, 24'h0000FF)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL tog_seq: got %0d bad want 0", bad); end
    step();
  endtask

  task automatic test_oor();
    int hs[3] = '{HA, 0, 3};
    int vs[3] = '{0, VA, 3};
    log_q.delete();
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_pre: got %b want 0", err_oor); end
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_h = H_W'(hs[i]); wr_v = V_W'(vs[i]); wr_data = 24'h111111 * 24'(i + 1);
      #1;
      if (i > 0) begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL oor_we%0d: got %b want 0", i, mem_we); end
      end
      step();
    end
    wr_req = 1'b0;
    repeat (3) step();
    checks++; if (log_q.size() != 1) begin errors++; $display("FAIL oor_cnt: got %0d want 1", log_q.size()); end
    if (log_q.size() > 0) begin
      checks++;
      if (log_q[0] !== ent(3, 3, 24'h333333)) begin errors++; $display("FAIL oor_ok: got %h want %h", log_q[0], ent(3, 3, 24'h333333)); end
    end
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_set: got %b want 1", err_oor); end
    repeat (5) step();
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b want 1", err_oor); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    clr_color = 24'hAAAAAA; clr_start = 1'b1; vga_valid = 1'b0;
    step();
    clr_start = 1'b0;
    repeat (20) step();
    vga_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wr_h = H_W'(i + 1); wr_v = V_W'(i + 1); wr_data = 24'h400000 + 24'(i);
      step();
    end
    wr_req = 1'b0;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", clr_busy); end
    #1;
    resetn = 1'b0; vga_valid = 1'b0;
    log_q.delete();
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", clr_busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", wr_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", mem_we); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL mid_oor: got %b want 0", err_oor); end
    repeat (2) step();
    resetn = 1'b1;
    repeat (20) step();
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL mid_nowr: got %0d want 0", log_q.size()); end
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL mid_nodone: got %0d want 0", done_cnt - d0); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", clr_busy); end
  endtask

  initial begin
    resetn = 1'b0; vga_valid = 1'b0; vga_h_addr = '0; vga_v_addr = '0;
    wr_req = 1'b0; wr_h = '0; wr_v = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0; mem_rdata = '0;
    step();
    test_reset();
    test_read();
    test_fifo_order();
    test_hold();
    test_clear_full();
    test_clear_toggle();
    test_oor();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port access arbiter and sequencer for the 24-bit VGA frame buffer. Shares the one buffer port between three users, in priority order: the VGA scan-out read (highest), an internal full-screen clear engine, and a 4-entry FIFO of pixel writes from a producer such as the keyboard/text logic. It sits between `vga_ctrl` and the frame-buffer memory and drives that memory's address, write-enable and write-data lines.

## Interface
- `H_W`, 10: horizontal address width
- `V_W`, 9: vertical address width
- `DW`, 24: pixel width, RGB888
- `H_ACTIVE`, 640: visible columns; clear range and write-legality limit
- `V_ACTIVE`, 480: visible rows
- `FIFO_DEPTH`, 4: write FIFO entries, a power of two
- `clock` in 1: the single clock; all state updates on its rising edge
- `resetn` in 1: asynchronous, active-low reset
- `vga_valid` in 1: display active; the scan-out owns the port this cycle
- `vga_h_addr` in H_W: scan-out column
- `vga_v_addr` in V_W: scan-out row
- `vga_data` out DW: pixel returned to `vga_ctrl`
- `wr_req` in 1: push request
- `wr_h` in H_W: write column
- `wr_v` in V_W: write row
- `wr_data` in DW: write pixel
- `wr_ready` out 1: FIFO not full
- `clr_start` in 1: start a clear; pulse or level
- `clr_color` in DW: clear colour, sampled at start
- `clr_busy` out 1: clear in progress
- `clr_done` out 1: one-cycle pulse when a clear completes
- `err_oor` out 1: sticky flag, set when an out-of-range write is dropped
- `mem_addr` out H_W+V_W: buffer address `{h, v}`
- `mem_we` out 1: synchronous write enable
- `mem_wdata` out DW: buffer write data
- `mem_rdata` in DW: combinational read data from the buffer

## Operation
- Port mux, combinational, evaluated every cycle, first match wins:
  1. `vga_valid`=1: `mem_addr={vga_h_addr,vga_v_addr}`, `mem_we`=0, `vga_data=mem_rdata`.
  2. State CLEAR: `mem_addr={clr_h,clr_v}`, `mem_we`=1, `mem_wdata`=latched colour.
  3. FIFO not empty: address and data from the FIFO head; `mem_we`=1 only if the head is in range; the head is popped.
  4. Otherwise: `mem_addr`=0, `mem_we`=0.
- `vga_data` = `mem_rdata` when `vga_valid`=1, else 0.
- FSM states IDLE and CLEAR.
  - IDLE → CLEAR on `clr_start`=1. This latches `clr_color` and sets `clr_h`=0, `clr_v`=0.
  - `clr_start` is ignored while in CLEAR.
- Clear walk: advances only on cycles where the clear owns the port (`vga_valid`=0).
  - `clr_h` increments and wraps from H_ACTIVE-1 to 0; `clr_v` increments on each wrap.
  - The write at (H_ACTIVE-1, V_ACTIVE-1) is the last one. The FSM then returns to IDLE and `clr_done` is registered high for exactly one cycle.
- Write FIFO:
  - Push when `wr_req`=1 and `wr_ready`=1. `wr_ready` = count < FIFO_DEPTH, with no dependence on a same-cycle pop.
  - No bypass: an entry pushed in cycle N is poppable from cycle N+1.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits.
- Range check at pop: an entry is out of range if `wr_h` ≥ H_ACTIVE or `wr_v` ≥ V_ACTIVE.
  - An out-of-range entry is still popped and consumes its slot, but `mem_we`=0.
  - It sets `err_oor`=1, which holds until reset.
- A clear does not flush the FIFO. Entries pending at `clr_start` are written after the clear completes, so they land on top of the cleared image.

## Timing
- Reset, asynchronous on `resetn`=0:
  - FSM to IDLE, FIFO emptied, clear counters 0.
  - `clr_busy`=0, `clr_done`=0, `err_oor`=0, `wr_ready`=1.
  - Combinational outputs follow the mux rules, so `mem_we`=0 unless CLEAR or a non-empty FIFO (neither holds in reset).
- Reset asserted mid-clear or mid-drain aborts immediately. No `clr_done`; FIFO contents are lost.
- `clr_busy` = (state==CLEAR), registered.
- Read latency is 0 cycles: `vga_data` follows address changes within the cycle.
- Write latency is at least 1 cycle from push to the `mem_we` edge. It is unbounded while `vga_valid`=1 or a clear is running.
- A clear needs exactly H_ACTIVE×V_ACTIVE cycles with `vga_valid`=0 (307200 at the defaults).
- `clr_start` and `wr_req` in the same cycle are both accepted.

## Test plan
- Reset, then `vga_valid`=1 with address (5,7) and `mem_rdata`=0xABCDEF.
  - Required: `vga_data`=0xABCDEF and `mem_we`=0 in that cycle. With `vga_valid`=0, `vga_data`=0.
- With `vga_valid`=0, push 4 writes in consecutive cycles.
  - Required: `wr_ready` falls only if pops lag, and `mem_we` pulses in FIFO order starting 1 cycle after the first push.
  - Hold `vga_valid`=1 with 4 entries queued: `wr_ready`=0 and no writes; after release, 4 writes occur in order.
- Clear with colour 0x00FF00 and `vga_valid`=0 continuously.
  - Required: 307200 `mem_we` cycles, the last at address {639,479}, then `clr_done` high for exactly 1 cycle and `clr_busy`=0.
- Clear with `vga_valid` toggling every other cycle.
  - Required: exactly 307200 writes with no address skipped. A second `clr_start` mid-clear has no effect.
- Push (640,0), then (0,480), then (3,3).
  - Required: the first two are popped without `mem_we`, `err_oor`=1 and sticky, and (3,3) is written.
- Assert `resetn`=0 mid-clear with 2 FIFO entries queued.
  - Required: immediate IDLE, `clr_busy`=0, `wr_ready`=1, no `clr_done`, and no further writes after release.
